// File: rtl/sqrt_pwl_eval.sv
// Pipelined piecewise-linear sqrt(e) for the Box-Muller datapath, 1 sample/clk with back-pressure.
// Optional feature macro SQRT_ROUND_EN: round-to-nearest (ties away) in the output stage instead of truncation.
module sqrt_pwl_eval #(
    parameter int IN_W     = 32,
    parameter int IN_FRAC  = 24,
    parameter int OUT_W    = 24,
    parameter int OUT_FRAC = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  e_in,
    output logic [5:0]       coef_addr,
    output logic             coef_sel,
    input  logic [31:0]      coef_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] f_out
);

    localparam int PW     = $clog2(IN_W);
    localparam int Y_FRAC = 23;
    localparam int ALIGN  = Y_FRAC - OUT_FRAC;
    localparam int YW     = 34;
    localparam int XW     = YW + 16;

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    logic [PW-1:0] p_next;
    always_comb begin
        p_next = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (e_in[i]) p_next = PW'(i);
        end
    end

    logic              s1_valid, s1_z;
    logic [IN_W-1:0]   s1_e;
    logic [PW-1:0]     s1_p;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_z     <= 1'b0;
            s1_e     <= '0;
            s1_p     <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_z     <= (e_in == '0);
            s1_e     <= e_in;
            s1_p     <= p_next;
        end
    end

    // Only the mantissa bits below the hidden one that feed address and offset are kept.
    logic [PW-1:0]      norm_sh;
    logic [17:0]        m_hi;
    logic signed [5:0]  k, kh_next;
    always_comb begin
        norm_sh = PW'(IN_W - 1) - s1_p;
        m_hi    = 18'((s1_e << norm_sh) >> (IN_W - 19));
        k       = 6'(s1_p) - 6'(IN_FRAC);
        kh_next = k >>> 1;
    end

    logic              s2_valid, s2_z;
    logic [11:0]       s2_dx;
    logic signed [5:0] s2_kh;
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_z      <= 1'b0;
            s2_dx     <= '0;
            s2_kh     <= '0;
            coef_addr <= '0;
            coef_sel  <= 1'b0;
        end else if (adv) begin
            s2_valid  <= s1_valid;
            s2_z      <= s1_z;
            s2_dx     <= m_hi[11:0];
            s2_kh     <= kh_next;
            coef_addr <= m_hi[17:12];
            coef_sel  <= k[0];
        end
    end

    // The ROM keeps re-reading the held address during a stall, which belongs to the
    // sample behind this one, so the word seen right after an advance is latched.
    logic              sr_valid, sr_z;
    logic [11:0]       sr_dx;
    logic signed [5:0] sr_kh;
    logic              adv_q;
    logic [31:0]       coef_hold, coef_eff;
    assign coef_eff = adv_q ? coef_data : coef_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_valid  <= 1'b0;
            sr_z      <= 1'b0;
            sr_dx     <= '0;
            sr_kh     <= '0;
            adv_q     <= 1'b1;
            coef_hold <= '0;
        end else begin
            adv_q     <= adv;
            coef_hold <= coef_eff;
            if (adv) begin
                sr_valid <= s2_valid;
                sr_z     <= s2_z;
                sr_dx    <= s2_dx;
                sr_kh    <= s2_kh;
            end
        end
    end

    logic [19:0]   slope;
    logic [11:0]   icpt;
    logic [31:0]   prod;
    logic [YW-1:0] y_next;
    always_comb begin
        slope  = coef_eff[31:12];
        icpt   = coef_eff[11:0];
        prod   = {12'b0, slope} * {20'b0, sr_dx};
        y_next = (YW'(1) << Y_FRAC) + {11'b0, icpt, 11'b0} + {2'b0, prod};
    end

    logic              s3_valid, s3_z;
    logic [YW-1:0]     s3_y;
    logic signed [5:0] s3_kh;
    always_ff @(posedge clk) begin
        if (reset) begin
            s3_valid <= 1'b0;
            s3_z     <= 1'b0;
            s3_y     <= '0;
            s3_kh    <= '0;
        end else if (adv) begin
            s3_valid <= sr_valid;
            s3_z     <= sr_z;
            s3_y     <= y_next;
            s3_kh    <= sr_kh;
        end
    end

    // Net shift combines the exponent half with the Q.23 -> Q.OUT_FRAC alignment.
    logic signed [6:0] net;
    logic [5:0]        rsh;
    logic [XW-1:0]     y_ext, shifted;
    logic [OUT_W-1:0]  f_next;
    always_comb begin
        net   = {s3_kh[5], s3_kh} - 7'(ALIGN);
        rsh   = 6'(-net);
        y_ext = {{(XW-YW){1'b0}}, s3_y};
        if (!net[6]) begin
            shifted = y_ext << net[5:0];
        end else begin
`ifdef SQRT_ROUND_EN
            y_ext = y_ext + (XW'(1) << (rsh - 6'd1));
`endif
            shifted = y_ext >> rsh;
        end
        if (|shifted[XW-1:OUT_W]) f_next = '1;
        else                      f_next = shifted[OUT_W-1:0];
        if (s3_z) f_next = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            f_out     <= '0;
        end else if (adv) begin
            out_valid <= s3_valid;
            f_out     <= f_next;
        end
    end

endmodule

// File: tb/tb_sqrt_pwl_eval.sv
// Bench for sqrt_pwl_eval: directed and random samples against an arithmetic sqrt model with its own ROM tables.
// Expected results follow SQRT_ROUND_EN when it is defined for the build.
module tb_sqrt_pwl_eval;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] e_in;
    logic [5:0]  coef_addr;
    logic        coef_sel;
    logic [31:0] coef_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] f_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] rom1 [64];
    logic [31:0] rom2 [64];

    always #5 clk = ~clk;

    always_ff @(posedge clk) coef_data <= coef_sel ? rom2[coef_addr] : rom1[coef_addr];

    sqrt_pwl_eval dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .e_in(e_in),
        .coef_addr(coef_addr), .coef_sel(coef_sel), .coef_data(coef_data),
        .out_valid(out_valid), .out_ready(out_ready), .f_out(f_out)
    );

    // Segment a covers x in [1+a/64, 1+(a+1)/64); table 2 holds sqrt(2x).
    task automatic build_roms();
        for (int a = 0; a < 64; a++) begin
            for (int t = 0; t < 2; t++) begin
                real x0, x1, f0, f1;
                int  ii, ss;
                x0 = (1.0 + a / 64.0) * (t + 1);
                x1 = (1.0 + (a + 1) / 64.0) * (t + 1);
                f0 = $sqrt(x0);
                f1 = $sqrt(x1);
                ii = int'((f0 - 1.0) * 4096.0);
                if (ii > 4095) ii = 4095;
                ss = int'((f1 - f0) * 2048.0);
                if (t == 0) rom1[a] = {20'(ss), 12'(ii)};
                else        rom2[a] = {20'(ss), 12'(ii)};
            end
        end
    endtask

    function automatic longint model_y(input logic [31:0] e, output int kh);
        int          p, k;
        logic [31:0] m, w;
        logic [5:0]  a;
        logic [11:0] dx;
        p = 31;
        while (p > 0 && e[p] == 1'b0) p--;
        k  = p - 24;
        m  = e << (31 - p);
        a  = m[30:25];
        dx = m[24:13];
        if (k % 2 != 0) begin
            w  = rom2[a];
            kh = (k - 1) / 2;
        end else begin
            w  = rom1[a];
            kh = k / 2;
        end
        return 64'd8388608 + longint'(w[11:0]) * 2048 + longint'(w[31:12]) * longint'(dx);
    endfunction

    function automatic logic [23:0] model_f(input logic [31:0] e);
        longint y, scaled;
        int     kh;
        if (e == 32'd0) return 24'd0;
        y      = model_y(e, kh);
        scaled = y << (kh + 12);
`ifdef SQRT_ROUND_EN
        scaled = scaled + 64'd16384;
`endif
        scaled = scaled >> 15;
        if (scaled > 64'd16777215) return 24'hFFFFFF;
        return scaled[23:0];
    endfunction

    function automatic logic [31:0] rand_e();
        if ($urandom_range(0, 9) == 0) return 32'd0;
        return $urandom >> $urandom_range(0, 31);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [23:0] obs, input real ideal);
        real diff;
        checks++;
        diff = $itor(obs) - ideal;
        assert (diff <= 256.0 && diff >= -256.0)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected approx %f", tag, obs, ideal);
        end
    endtask

    // Sends one sample into an empty pipe, checks routing, latency and value, then drains it.
    task automatic apply_stimulus(input logic [31:0] e, input logic exp_sel, input logic [5:0] exp_addr,
                                  input string tag, output logic [23:0] got);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        e_in      = e;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        for (int n = 0; n < 12; n++) begin
            if (n == 1) begin
                check_output({tag, "_sel"}, 32'(coef_sel), 32'(exp_sel));
                check_output({tag, "_addr"}, 32'(coef_addr), 32'(exp_addr));
            end
            if (out_valid) begin
                lat = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        check_output({tag, "_lat"}, 32'(lat), 32'd4);
        got = f_out;
        check_output({tag, "_f"}, 32'(f_out), 32'(model_f(e)));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [23:0] got, expv, prev_f, trunc;
        logic [23:0] q [$];
        logic [31:0] cur_e, e_r;
        logic [5:0]  prev_addr;
        logic        prev_hold, seen, found;
        longint      y;
        int          kh, sent, rcvd, ra;

        in_valid  = 1'b0;
        e_in      = '0;
        out_ready = 1'b1;
        reset     = 1'b1;
        build_roms();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_f_out", 32'(f_out), 32'd0);
        check_output("rst_coef_addr", 32'(coef_addr), 32'd0);
        check_output("rst_coef_sel", 32'(coef_sel), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);

        apply_stimulus(32'h0100_0000, 1'b0, 6'd0, "one", got);
        check_output("one_exact", 32'(got), 32'h0010_0000);
        apply_stimulus(32'h0200_0000, 1'b1, 6'd0, "two", got);
        check_near("two_near", got, 1482910.4);
        apply_stimulus(32'h0400_0000, 1'b0, 6'd0, "four", got);
        check_output("four_exact", 32'(got), 32'h0020_0000);
        apply_stimulus(32'h0080_0000, 1'b1, 6'd0, "half", got);
        check_near("half_near", got, 741455.2);
        apply_stimulus(32'h0000_0000, 1'b0, 6'd0, "zero", got);
        check_output("zero_val", 32'(got), 32'd0);
        apply_stimulus(32'hFFFF_FFFF, 1'b1, 6'd63, "max", got);
        check_output("max_top", 32'(got[23:16]), 32'hFF);

        // k=-2 with dx=8 and an odd slope leaves exactly half an output LSB below the cut.
        found = 1'b0;
        ra    = 0;
        for (int a = 0; a < 64; a++) begin
            if (!found && rom1[a][12]) begin
                found = 1'b1;
                ra    = a;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $error("[TB] FAIL round_search observed=none expected=odd slope");
        end else begin
            e_r = (32'h8000_0000 | (32'(ra) << 25) | (32'd8 << 13)) >> 9;
            apply_stimulus(e_r, 1'b0, 6'(ra), "round", got);
            y     = model_y(e_r, kh);
            trunc = 24'(y >> 4);
`ifdef SQRT_ROUND_EN
            expv = trunc + 24'd1;
`else
            expv = trunc;
`endif
            check_output("round_half", 32'(got), 32'(expv));
        end

        sent      = 0;
        rcvd      = 0;
        prev_hold = 1'b0;
        prev_f    = '0;
        prev_addr = '0;
        cur_e     = rand_e();
        @(negedge clk);
        for (int cyc = 0; cyc < 4000 && rcvd < 100; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 100);
            e_in      = cur_e;
            #1;
            if (prev_hold) begin
                check_output("hold_f", 32'(f_out), 32'(prev_f));
                check_output("hold_addr", 32'(coef_addr), 32'(prev_addr));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("[TB] FAIL stream_extra observed=0x%0h expected=no output", f_out);
                end else begin
                    expv = q.pop_front();
                    check_output("stream_f", 32'(f_out), 32'(expv));
                    rcvd++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model_f(cur_e));
                sent++;
                cur_e = rand_e();
            end
            prev_hold = out_valid && !out_ready;
            prev_f    = f_out;
            prev_addr = coef_addr;
            @(negedge clk);
        end
        check_output("stream_count", 32'(rcvd), 32'd100);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            e_in     = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        check_output("flight_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("rst_flush", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        seen      = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check_output("rst_no_stale", 32'(seen), 32'd0);
        apply_stimulus(32'h0030_0000, 1'b1, 6'd32, "post_rst", got);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
